// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one serial-load booth multiplier.
// Grants one operand pair at a time, loads it, waits for done or timeout.
module booth_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_data_in,
    input  logic                  mul_done,
    input  logic [WIDTH-1:0]      mul_out
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        LOAD_M,
        LOAD_Q,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IDW-1:0]   rr;
    logic [IDW-1:0]   rr_n;
    logic [IDW-1:0]   gid;
    logic [IDW-1:0]   win;
    logic             any;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [CW-1:0]    cnt;
    logic             tmo;

    // Search from the rr pointer upward with wrap; first valid wins
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req_valid[(int'(rr) + k) % NREQ]) begin
                any = 1'b1;
                win = IDW'((int'(rr) + k) % NREQ);
            end
        end
    end

    assign rr_n = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    assign tmo  = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any) state_n = GRANT;
            GRANT:   state_n = req_valid[gid] ? ISSUE : IDLE;
            ISSUE:   state_n = LOAD_M;
            LOAD_M:  state_n = LOAD_Q;
            LOAD_Q:  state_n = WAIT;
            WAIT:    if (mul_done || tmo) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        mul_start   = 1'b0;
        mul_data_in = '0;
        case (state)
            GRANT:  req_ready[gid] = req_valid[gid];
            ISSUE:  mul_start = 1'b1;
            LOAD_M: begin
                mul_start   = 1'b1;
                mul_data_in = op_a;
            end
            LOAD_Q: begin
                mul_start   = 1'b1;
                mul_data_in = op_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr        <= '0;
            gid       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            cnt <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        gid <= win;
                        rr  <= rr_n;
                    end
                end
                GRANT: begin
                    if (req_valid[gid]) begin
                        op_a <= req_a[gid*WIDTH +: WIDTH];
                        op_b <= req_b[gid*WIDTH +: WIDTH];
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // done beats a coincident timeout
                    if (mul_done) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= gid;
                        rsp_data  <= mul_out;
                        rsp_err   <= 1'b0;
                    end else if (tmo) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= gid;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
